// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of one single-outstanding memory port.
// Rejects misaligned accesses, builds byte lanes for stores and returns extended load data.
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            if_err_o,
    input  logic            dm_req_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic            dm_wr_i,
    input  logic [1:0]      dm_byte_i,
    input  logic            dm_zero_extnd_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [XLEN-1:0] dm_rdata_o,
    output logic            dm_err_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    localparam logic       OWN_IF  = 1'b0;
    localparam logic       OWN_DM  = 1'b1;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] off, input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_data(input logic [XLEN-1:0] wdata,
                                                  input logic [1:0]      size);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Half-words reaching here are aligned, so off*8 equals 16*off[1].
    function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] word,
                                                    input logic [1:0]      off,
                                                    input logic [1:0]      size,
                                                    input logic            zext);
        logic [XLEN-1:0] shifted;
        logic [7:0]      b;
        logic [15:0]     h;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = shifted[15:0];
        case (size)
            SZ_BYTE: return {{(XLEN-8){b[7] & ~zext}}, b};
            SZ_HALF: return {{(XLEN-16){h[15] & ~zext}}, h};
            default: return word;
        endcase
    endfunction

    state_e          state_q;
    logic            last_owner_q;
    logic            owner_q;
    logic            wr_q;
    logic            zext_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      be_q;
    logic            if_rvalid_q;
    logic            if_err_q;
    logic [XLEN-1:0] if_rdata_q;
    logic            dm_rvalid_q;
    logic            dm_err_q;
    logic [XLEN-1:0] dm_rdata_q;

    logic            pick_dm;
    logic            grant;
    logic [XLEN-1:0] sel_addr;
    logic [1:0]      sel_size;
    logic            sel_wr;
    logic            sel_err;

    // On a tie the requester that did not own the port last time wins.
    always_comb begin
        if (if_req_i && dm_req_i) begin
            pick_dm = (last_owner_q == OWN_IF);
        end else begin
            pick_dm = dm_req_i;
        end
        grant    = rst_n && (state_q == S_IDLE) && (if_req_i || dm_req_i);
        sel_addr = pick_dm ? dm_addr_i : if_addr_i;
        sel_size = pick_dm ? dm_byte_i : SZ_WORD;
        sel_wr   = pick_dm & dm_wr_i;
        sel_err  = is_misaligned(sel_addr[1:0], sel_size);
    end

    assign if_gnt_o    = grant & ~pick_dm;
    assign dm_gnt_o    = grant & pick_dm;

    assign mem_req_o   = (state_q == S_ISSUE);
    assign mem_addr_o  = mem_req_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_we_o    = mem_req_o & wr_q;
    assign mem_be_o    = mem_req_o ? be_q : 4'b0000;
    assign mem_wdata_o = mem_req_o ? wdata_q : '0;

    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_err_o    = if_err_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_err_o    = dm_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_owner_q <= OWN_DM;
            owner_q      <= OWN_IF;
            wr_q         <= 1'b0;
            zext_q       <= 1'b0;
            size_q       <= SZ_BYTE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= 4'b0000;
            if_rvalid_q  <= 1'b0;
            if_err_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rvalid_q  <= 1'b0;
            dm_err_q     <= 1'b0;
            dm_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rvalid_q <= 1'b0;
            dm_err_q    <= 1'b0;
            dm_rdata_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        last_owner_q <= pick_dm;
                        owner_q      <= pick_dm;
                        addr_q       <= sel_addr;
                        wr_q         <= sel_wr;
                        size_q       <= sel_size;
                        zext_q       <= dm_zero_extnd_i;
                        wdata_q      <= sel_wr ? lane_data(dm_wdata_i, sel_size) : '0;
                        be_q         <= byte_enable(sel_addr[1:0], sel_size);
                        if (sel_err) begin
                            // Rejected accesses answer straight away and never touch memory.
                            state_q <= S_ERR;
                            if (pick_dm) begin
                                dm_rvalid_q <= 1'b1;
                                dm_err_q    <= 1'b1;
                            end else begin
                                if_rvalid_q <= 1'b1;
                                if_err_q    <= 1'b1;
                            end
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_gnt_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= S_IDLE;
                        if (owner_q == OWN_DM) begin
                            dm_rvalid_q <= 1'b1;
                            dm_rdata_q  <= wr_q ? '0
                                         : format_load(mem_rdata_i, addr_q[1:0], size_q, zext_q);
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= mem_rdata_i;
                        end
                    end
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
